fsm_run_initiator: RTL and testbench
====================================

Name: fsm_run_initiator

Overview:
Initiator side of the go/done handshake used by the counting FSM responder. It conditions a raw active-low start button by synchronizing, debouncing and detecting the press edge. On a press it drives an active-low go request and holds it until the responder's done signal is seen. It then waits for done to clear, counts completed runs, and flags a timeout if done never arrives.

Parameters:
DEBOUNCE_COUNT, 24'd60000, consecutive clk cycles the synced button must differ from its debounced value before the debounced value updates (5 ms at 12 MHz)
TIMEOUT_COUNT, 27'd100000000, max clk cycles spent in REQUEST before declaring a timeout (~8.3 s at 12 MHz)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start_btn  input  1  raw start button, active-low, asynchronous and bouncy
done_in  input  1  done level from responder, asynchronous to clk
go_n  output  1  go request to responder, active-low, registered
busy  output  1  high while a run is in progress (REQUEST or ACK)
run_count  output  4  completed-run counter, wraps
timeout_err  output  1  sticky timeout flag

Behaviour:
- Reset (async, rst=1): go_n=1, busy=0, run_count=0, timeout_err=0, state=IDLE. Button sync flops and debounced value go to 1 (released). Done sync flops go to 0. Debounce and timeout counters go to 0. rst mid-run releases go_n immediately.
- Synchronizers: two flops each on start_btn and done_in. All logic below uses the synced values btn_s and done_s.
- Debounce:
  - Counter increments each cycle while btn_s != btn_db and clears whenever they match.
  - On the cycle the counter reaches DEBOUNCE_COUNT-1 with a mismatch still present: btn_db <= btn_s and the counter clears.
  - press = registered 1-cycle pulse on each btn_db 1->0 transition. Release generates nothing.
- Press latency: go_n falls DEBOUNCE_COUNT+3 to DEBOUNCE_COUNT+5 clk edges after start_btn first goes low and stays low.
- FSM states: IDLE, REQUEST, ACK, ERROR.
  - IDLE: go_n=1, busy=0. On press with done_s=0, go to REQUEST. A press while done_s=1 is ignored.
  - REQUEST: go_n=0, busy=1. The timeout counter clears on entry and increments each cycle.
    - If done_s=1: go to ACK, and run_count <= run_count+1 (4-bit, 15 wraps to 0).
    - Else, if the counter reaches TIMEOUT_COUNT-1: go to ERROR.
    - If done and timeout occur in the same cycle, done wins.
  - ACK: go_n=1, busy=1. When done_s=0, go to IDLE. go_n is released while done is still high, so the responder sees go deasserted when it returns to idle and does not restart.
  - ERROR: go_n=1, busy=0, timeout_err=1. A press clears timeout_err and returns to IDLE without starting a run. The next press starts a run.
  - Unused or illegal state encodings return to IDLE.
- Presses in REQUEST or ACK are ignored; they are not queued.
- done_s rising while in IDLE or ERROR is ignored and has no count effect.
- go_n, busy and timeout_err are registered outputs decoded from the state register (Moore). run_count changes only on the REQUEST->ACK transition.

Test Plan:
(All scenarios use DEBOUNCE_COUNT=8, TIMEOUT_COUNT=100.)
1. Reset: assert rst with start_btn=1 and done_in=0 -> go_n=1, busy=0, run_count=0, timeout_err=0. Assert rst asynchronously mid-REQUEST -> go_n=1 and busy=0 before the next clk edge.
2. Bounce: toggle start_btn every 3 cycles for 30 cycles, then hold low for 40 cycles -> no go_n assertion during the bounce, exactly one go_n falling edge 11-13 cycles after the final low hold begins, and no second request.
3. Handshake: press; 20 cycles after go_n falls, drive done_in=1 for 10 cycles, then 0 ->
   - go_n=1 within 3 cycles of done rising
   - busy=1 until 2-3 cycles after done falls, then 0
   - run_count=1
4. Timeout: press and hold done_in=0 -> exactly 100 cycles after entering REQUEST, go_n=1, busy=0, timeout_err=1. Second press -> timeout_err=0 and go_n stays 1. Third press -> go_n=0 (new run).
5. Wrap: complete 16 handshakes -> run_count goes 1..15 and then 0, with timeout_err=0 throughout.
6. Ignored inputs:
   - press while busy -> no count change and no extra request
   - press while done_in=1 in IDLE -> go_n stays 1
   - done_in pulse in IDLE -> run_count unchanged

Source files
------------

// File: rtl/fsm_run_initiator.sv
// Initiator for the go/done handshake: conditions a raw start button, issues an
// active-low go request, counts completed runs and flags a missing done.
module fsm_run_initiator #(
    parameter logic [23:0] DEBOUNCE_COUNT = 24'd60000,
    parameter logic [26:0] TIMEOUT_COUNT  = 27'd100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       done_in,
    output logic       go_n,
    output logic       busy,
    output logic [3:0] run_count,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        ACK     = 2'd2,
        ERROR   = 2'd3
    } state_t;

    logic        r_btn_meta;
    logic        r_btn_s;
    logic        r_done_meta;
    logic        r_done_s;
    logic [23:0] r_db_cnt;
    logic        r_btn_db;
    logic        r_btn_db_prev;
    logic        r_press;
    logic [26:0] r_to_cnt;
    state_t      r_state;
    state_t      w_next;
    logic        r_go_n;
    logic        r_busy;
    logic        r_timeout_err;
    logic [3:0]  r_run_count;
    logic        w_db_hit;
    logic        w_timeout_hit;

    // The button idles high (released) and done idles low, so the sync chains reset to those levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_meta  <= 1'b1;
            r_btn_s     <= 1'b1;
            r_done_meta <= 1'b0;
            r_done_s    <= 1'b0;
        end else begin
            r_btn_meta  <= start_btn;
            r_btn_s     <= r_btn_meta;
            r_done_meta <= done_in;
            r_done_s    <= r_done_meta;
        end
    end

    assign w_db_hit = (r_db_cnt == DEBOUNCE_COUNT - 24'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_cnt <= '0;
            r_btn_db <= 1'b1;
        end else if (r_btn_s != r_btn_db) begin
            if (w_db_hit) begin
                r_btn_db <= r_btn_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 24'd1;
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    // Press is a single-cycle pulse on the debounced falling edge only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_db_prev <= 1'b1;
            r_press       <= 1'b0;
        end else begin
            r_btn_db_prev <= r_btn_db;
            r_press       <= r_btn_db_prev & ~r_btn_db;
        end
    end

    assign w_timeout_hit = (r_to_cnt == TIMEOUT_COUNT - 27'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state != REQUEST) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 27'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (r_press && !r_done_s) begin
                    w_next = REQUEST;
                end
            end
            REQUEST: begin
                if (r_done_s) begin
                    w_next = ACK;
                end else if (w_timeout_hit) begin
                    w_next = ERROR;
                end
            end
            ACK: begin
                if (!r_done_s) begin
                    w_next = IDLE;
                end
            end
            ERROR: begin
                if (r_press) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they switch together with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_go_n        <= 1'b1;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_go_n        <= (w_next != REQUEST);
            r_busy        <= (w_next == REQUEST) || (w_next == ACK);
            r_timeout_err <= (w_next == ERROR);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_count <= '0;
        end else if (r_state == REQUEST && r_done_s) begin
            r_run_count <= r_run_count + 4'd1;
        end
    end

    assign go_n        = r_go_n;
    assign busy        = r_busy;
    assign run_count   = r_run_count;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_fsm_run_initiator.sv
// Directed plus randomized bench for fsm_run_initiator, checked against a
// transaction-level model of presses, handshakes and timeouts.
`timescale 1ns/1ps
module tb_fsm_run_initiator;

    localparam int DC = 8;
    localparam int TC = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_btn;
    logic       done_in;
    logic       go_n;
    logic       busy;
    logic [3:0] run_count;
    logic       timeout_err;

    int nVec = 0;
    int nErr = 0;
    int expRunCount = 0;
    int cyc = 0;
    int goFalls = 0;
    int goFallCyc = 0;
    int pressStartCyc = 0;
    int pressFallsBefore = 0;
    logic prevGo = 1'b1;

    fsm_run_initiator #(
        .DEBOUNCE_COUNT(24'(DC)),
        .TIMEOUT_COUNT (27'(TC))
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_btn  (start_btn),
        .done_in    (done_in),
        .go_n       (go_n),
        .busy       (busy),
        .run_count  (run_count),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every go request (falling go_n) and the clock edge it happened on.
    always @(negedge clk) begin
        if (prevGo === 1'b1 && go_n === 1'b0) begin
            goFalls   <= goFalls + 1;
            goFallCyc <= cyc;
        end
        prevGo <= go_n;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic btn, input logic done);
        start_btn = btn;
        done_in   = done;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nVec++;
        assert (observed === expected)
        else begin
            nErr++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkRange(input string tag, input int observed, input int lo, input int hi);
        nVec++;
        assert (observed >= lo && observed <= hi)
        else begin
            nErr++;
            $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, observed, lo, hi);
        end
    endtask

    // Random short bounce (never long enough to debounce), then a clean hold and release.
    task automatic pressButton(input bit doBounce);
        int pairs;
        if (doBounce) begin
            pairs = $urandom_range(0, 3);
            for (int p = 0; p < pairs; p++) begin
                start_btn = 1'b0;
                tick($urandom_range(1, 5));
                start_btn = 1'b1;
                tick($urandom_range(1, 5));
            end
        end
        start_btn        = 1'b0;
        pressStartCyc    = cyc;
        pressFallsBefore = goFalls;
        tick(DC + 8);
        start_btn = 1'b1;
        tick(DC + 4);
    endtask

    task automatic expectGoStart(input string tag);
        checkOutput({tag, "Falls"}, goFalls - pressFallsBefore, 1);
        checkRange({tag, "Latency"}, goFallCyc - pressStartCyc, DC + 3, DC + 5);
    endtask

    task automatic handshake(input int delay, input int dur, input string tag);
        int riseAt;
        int dropAt;
        riseAt = -1;
        dropAt = -1;
        tick(delay);
        done_in = 1'b1;
        for (int i = 1; i <= dur; i++) begin
            tick(1);
            if (riseAt < 0 && go_n === 1'b1) riseAt = i;
        end
        checkOutput({tag, "BusyHeld"}, {31'd0, busy}, 1);
        done_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            if (dropAt < 0 && busy === 1'b0) dropAt = i;
        end
        expRunCount = (expRunCount + 1) % 16;
        checkRange({tag, "GoRelease"}, riseAt, 1, 3);
        checkRange({tag, "BusyDrop"}, dropAt, 2, 3);
        checkOutput({tag, "RunCount"}, {28'd0, run_count}, expRunCount);
        checkOutput({tag, "TimeoutErr"}, {31'd0, timeout_err}, 0);
    endtask

    initial begin
        int waited;
        int delay;

        // Reset state
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0);
        tick(3);
        checkOutput("rstGoN", {31'd0, go_n}, 1);
        checkOutput("rstBusy", {31'd0, busy}, 0);
        checkOutput("rstRunCount", {28'd0, run_count}, 0);
        checkOutput("rstTimeoutErr", {31'd0, timeout_err}, 0);
        rst = 1'b0;
        tick(3);

        // Bounce every 3 cycles, then a long hold gives exactly one request
        pressFallsBefore = goFalls;
        for (int k = 0; k < 10; k++) begin
            start_btn = (k % 2 == 0) ? 1'b0 : 1'b1;
            tick(3);
        end
        checkOutput("bounceNoGo", goFalls - pressFallsBefore, 0);
        checkOutput("bounceGoN", {31'd0, go_n}, 1);
        start_btn        = 1'b0;
        pressStartCyc    = cyc;
        pressFallsBefore = goFalls;
        tick(40);
        expectGoStart("bounce");
        start_btn = 1'b1;
        tick(DC + 4);
        checkOutput("bounceOneReq", goFalls - pressFallsBefore, 1);
        handshake($urandom_range(1, 20), $urandom_range(4, 15), "bounceHs");

        // Handshake: done raised 20 cycles after go falls, held 10 cycles
        pressButton(1'b1);
        expectGoStart("hsGo");
        delay = 20 - (cyc - goFallCyc);
        if (delay < 0) delay = 0;
        handshake(delay, 10, "hs");

        // Asynchronous reset in the middle of a request
        pressButton(1'b1);
        expectGoStart("midRstGo");
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midRstGoN", {31'd0, go_n}, 1);
        checkOutput("midRstBusy", {31'd0, busy}, 0);
        tick(2);
        rst = 1'b0;
        expRunCount = 0;
        tick(2);
        checkOutput("midRstRunCount", {28'd0, run_count}, expRunCount);

        // Timeout, clear with a press, restart with the next press
        pressButton(1'b1);
        expectGoStart("toGo");
        waited = 0;
        while (go_n === 1'b0 && waited < TC + 20) begin
            tick(1);
            waited++;
        end
        checkOutput("toCycles", cyc - goFallCyc, TC);
        checkOutput("toBusy", {31'd0, busy}, 0);
        checkOutput("toErr", {31'd0, timeout_err}, 1);
        checkOutput("toRunCount", {28'd0, run_count}, expRunCount);
        pressButton(1'b1);
        checkOutput("toClearNoGo", goFalls - pressFallsBefore, 0);
        checkOutput("toClearGoN", {31'd0, go_n}, 1);
        checkOutput("toClearErr", {31'd0, timeout_err}, 0);
        pressButton(1'b1);
        expectGoStart("toRestart");
        handshake($urandom_range(1, 20), $urandom_range(4, 15), "toRestartHs");

        // Sixteen runs from reset wrap the counter back to zero
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        expRunCount = 0;
        tick(2);
        for (int r = 0; r < 16; r++) begin
            pressButton(1'b1);
            expectGoStart("wrapGo");
            handshake($urandom_range(1, 20), $urandom_range(4, 15), "wrap");
        end
        checkOutput("wrapFinal", {28'd0, run_count}, 0);

        // Presses during REQUEST and ACK are dropped
        pressButton(1'b1);
        expectGoStart("ignGo");
        pressButton(1'b1);
        checkOutput("ignReqNoNew", goFalls - pressFallsBefore, 0);
        checkOutput("ignReqGoN", {31'd0, go_n}, 0);
        done_in = 1'b1;
        tick(5);
        pressButton(1'b1);
        checkOutput("ignAckNoNew", goFalls - pressFallsBefore, 0);
        checkOutput("ignAckGoN", {31'd0, go_n}, 1);
        checkOutput("ignAckBusy", {31'd0, busy}, 1);
        done_in = 1'b0;
        tick(5);
        expRunCount = (expRunCount + 1) % 16;
        checkOutput("ignRunCount", {28'd0, run_count}, expRunCount);
        checkOutput("ignIdleBusy", {31'd0, busy}, 0);

        // Press while done is still high in IDLE
        done_in = 1'b1;
        tick(4);
        pressButton(1'b1);
        checkOutput("ignDoneHighNoGo", goFalls - pressFallsBefore, 0);
        checkOutput("ignDoneHighGoN", {31'd0, go_n}, 1);
        done_in = 1'b0;
        tick(4);

        // Done pulse in IDLE has no effect
        applyStimulus(1'b1, 1'b1);
        tick(5);
        applyStimulus(1'b1, 1'b0);
        tick(5);
        checkOutput("idleDoneRunCount", {28'd0, run_count}, expRunCount);
        checkOutput("idleDoneBusy", {31'd0, busy}, 0);
        checkOutput("idleDoneGoN", {31'd0, go_n}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
